// File: rtl/minhash_sketch_ctrl.sv
// Sequencer for one bottom-k MinHash sketch per sequence: clears the sorter, loads
// indexed signatures, waits for the sorter to settle, then streams retained indices.
module minhash_sketch_ctrl #(
    parameter int SIGNATURE_WIDTH = 32,
    parameter int INDEX_WIDTH     = 10,
    parameter int NUM_COMPARATORS = 8,
    parameter int LOG_COMPARATORS = 3,
    parameter int SORTER_LATENCY  = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   overflow,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [SIGNATURE_WIDTH-1:0]             in_signature,
    input  logic                                   in_last,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [INDEX_WIDTH-1:0]                 out_index,
    output logic                                   out_last,
    output logic                                   sorter_clear,
    output logic                                   sorter_load,
    output logic [SIGNATURE_WIDTH-1:0]             sorter_signature,
    output logic [INDEX_WIDTH-1:0]                 sorter_index,
    input  logic [NUM_COMPARATORS*INDEX_WIDTH-1:0] sorter_indices
);

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, DRAIN, OUTPUT} state_t;

    localparam int COUNT_WIDTH = LOG_COMPARATORS + 1;
    localparam int DRAIN_WIDTH = $clog2(SORTER_LATENCY + 2);
    localparam logic [INDEX_WIDTH:0] ITEMS_FULL = {1'b1, {INDEX_WIDTH{1'b0}}};
    localparam logic [INDEX_WIDTH:0] NC_ITEMS   = (INDEX_WIDTH + 1)'(NUM_COMPARATORS);

    state_t                   state;
    logic [INDEX_WIDTH-1:0]   idx;
    logic [INDEX_WIDTH:0]     items;
    logic [DRAIN_WIDTH-1:0]   drain_count;
    logic [INDEX_WIDTH-1:0]   snapshot [NUM_COMPARATORS];
    logic [COUNT_WIDTH-1:0]   count;
    logic [COUNT_WIDTH-1:0]   ptr;

    logic                     in_fire;
    logic                     out_fire;
    logic [COUNT_WIDTH-1:0]   ptr_next;
    logic [COUNT_WIDTH-1:0]   snap_count;

    assign in_fire    = in_valid & in_ready;
    assign out_fire   = out_valid & out_ready;
    assign ptr_next   = ptr + COUNT_WIDTH'(1);
    assign snap_count = (items >= NC_ITEMS) ? COUNT_WIDTH'(NUM_COMPARATORS) : COUNT_WIDTH'(items);

    // Once the index space is used up, beats are still accepted so the upstream
    // never stalls, but they are dropped and flagged through overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            overflow         <= 1'b0;
            in_ready         <= 1'b0;
            out_valid        <= 1'b0;
            out_index        <= '0;
            out_last         <= 1'b0;
            sorter_clear     <= 1'b0;
            sorter_load      <= 1'b0;
            sorter_signature <= '0;
            sorter_index     <= '0;
            idx              <= '0;
            items            <= '0;
            drain_count      <= '0;
            count            <= '0;
            ptr              <= '0;
            for (int k = 0; k < NUM_COMPARATORS; k++) snapshot[k] <= '0;
        end else begin
            sorter_clear     <= 1'b0;
            sorter_load      <= 1'b0;
            sorter_signature <= '0;
            sorter_index     <= '0;
            done             <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        overflow     <= 1'b0;
                        idx          <= '0;
                        items        <= '0;
                        sorter_clear <= 1'b1;
                        busy         <= 1'b1;
                        state        <= CLEAR;
                    end
                end
                CLEAR: begin
                    in_ready <= 1'b1;
                    state    <= LOAD;
                end
                LOAD: begin
                    if (in_fire) begin
                        if (items == ITEMS_FULL) begin
                            overflow <= 1'b1;
                        end else begin
                            sorter_load      <= 1'b1;
                            sorter_signature <= in_signature;
                            sorter_index     <= idx;
                            items            <= items + (INDEX_WIDTH + 1)'(1);
                            if (idx != '1) idx <= idx + INDEX_WIDTH'(1);
                        end
                        if (in_last) begin
                            in_ready    <= 1'b0;
                            drain_count <= DRAIN_WIDTH'(SORTER_LATENCY);
                            state       <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_count != '0) begin
                        drain_count <= drain_count - DRAIN_WIDTH'(1);
                    end else begin
                        for (int k = 0; k < NUM_COMPARATORS; k++)
                            snapshot[k] <= sorter_indices[k*INDEX_WIDTH +: INDEX_WIDTH];
                        count <= snap_count;
                        ptr   <= '0;
                        if (snap_count == '0) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            out_valid <= 1'b1;
                            out_index <= sorter_indices[0 +: INDEX_WIDTH];
                            out_last  <= (snap_count == COUNT_WIDTH'(1));
                            state     <= OUTPUT;
                        end
                    end
                end
                OUTPUT: begin
                    if (out_fire) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_index <= '0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            ptr       <= ptr_next;
                            out_index <= snapshot[ptr_next[LOG_COMPARATORS-1:0]];
                            out_last  <= (ptr_next == count - COUNT_WIDTH'(1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_minhash_sketch_ctrl.sv
// Directed bench for minhash_sketch_ctrl: a 10-bit-index instance for the main sketches
// and a 3-bit-index instance for index exhaustion, each driving a bottom-8 sorter model.
module tb_minhash_sketch_ctrl;

    logic clk;
    logic reset;
    int   cycle = 0;
    int   checks = 0;
    int   errors = 0;

    logic        start_a, busy_a, done_a, overflow_a, in_valid_a, in_ready_a, in_last_a;
    logic        out_valid_a, out_ready_a, out_last_a, sorter_clear_a, sorter_load_a;
    logic [31:0] in_signature_a, sorter_signature_a;
    logic [9:0]  out_index_a, sorter_index_a;
    logic [79:0] sorter_indices_a;

    logic        start_b, busy_b, done_b, overflow_b, in_valid_b, in_ready_b, in_last_b;
    logic        out_valid_b, out_ready_b, out_last_b, sorter_clear_b, sorter_load_b;
    logic [31:0] in_signature_b, sorter_signature_b;
    logic [2:0]  out_index_b, sorter_index_b;
    logic [23:0] sorter_indices_b;

    minhash_sketch_ctrl #(.INDEX_WIDTH(10)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
        .overflow(overflow_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_signature(in_signature_a), .in_last(in_last_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .out_index(out_index_a), .out_last(out_last_a),
        .sorter_clear(sorter_clear_a), .sorter_load(sorter_load_a),
        .sorter_signature(sorter_signature_a), .sorter_index(sorter_index_a),
        .sorter_indices(sorter_indices_a)
    );

    minhash_sketch_ctrl #(.INDEX_WIDTH(3)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
        .overflow(overflow_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_signature(in_signature_b), .in_last(in_last_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .out_index(out_index_b), .out_last(out_last_b),
        .sorter_clear(sorter_clear_b), .sorter_load(sorter_load_b),
        .sorter_signature(sorter_signature_b), .sorter_index(sorter_index_b),
        .sorter_indices(sorter_indices_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    // Bottom-8 sorter models: insertion happens at the load edge and the slot bus is
    // re-registered once more, giving the two-cycle load-to-visible latency.
    logic [31:0] msig_a [8];
    logic [9:0]  midx_a [8];
    always @(posedge clk) begin : sorter_model_a
        logic [79:0] bus;
        int p;
        for (int k = 0; k < 8; k++) bus[k*10 +: 10] = midx_a[k];
        sorter_indices_a <= bus;
        if (sorter_clear_a) begin
            for (int k = 0; k < 8; k++) begin msig_a[k] = '1; midx_a[k] = '0; end
        end else if (sorter_load_a && sorter_signature_a < msig_a[7]) begin
            p = 7;
            while (p > 0 && msig_a[p-1] > sorter_signature_a) begin
                msig_a[p] = msig_a[p-1]; midx_a[p] = midx_a[p-1]; p--;
            end
            msig_a[p] = sorter_signature_a; midx_a[p] = sorter_index_a;
        end
    end

    logic [31:0] msig_b [8];
    logic [2:0]  midx_b [8];
    always @(posedge clk) begin : sorter_model_b
        logic [23:0] bus;
        int p;
        for (int k = 0; k < 8; k++) bus[k*3 +: 3] = midx_b[k];
        sorter_indices_b <= bus;
        if (sorter_clear_b) begin
            for (int k = 0; k < 8; k++) begin msig_b[k] = '1; midx_b[k] = '0; end
        end else if (sorter_load_b && sorter_signature_b < msig_b[7]) begin
            p = 7;
            while (p > 0 && msig_b[p-1] > sorter_signature_b) begin
                msig_b[p] = msig_b[p-1]; midx_b[p] = midx_b[p-1]; p--;
            end
            msig_b[p] = sorter_signature_b; midx_b[p] = sorter_index_b;
        end
    end

    // Every sorter_load must be exactly one cycle behind an input handshake.
    int   load_q_a [$];
    int   load_q_b [$];
    int   clear_cnt_a = 0;
    int   trail_errs = 0;
    logic prev_hs_a = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            prev_hs_a = 1'b0;
        end else begin
            if (sorter_load_a) load_q_a.push_back(int'(sorter_index_a));
            if (sorter_load_b) load_q_b.push_back(int'(sorter_index_b));
            if (sorter_clear_a) clear_cnt_a++;
            if (sorter_load_a != prev_hs_a) trail_errs++;
            prev_hs_a = in_valid_a & in_ready_a;
        end
    end

    logic [31:0] beat_sig [$];
    int          exp_q [$];
    int          got_idx [$];
    bit          got_last [$];
    int          hs_last_cycle;
    int          first_valid_cycle;
    int          stall_errs;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic startSketchA();
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        @(negedge clk);
        checkOutput("clear_pulse", sorter_clear_a, 1);
        checkOutput("clear_not_ready", in_ready_a, 0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("load_ready", in_ready_a, 1);
        checkOutput("clear_one_cycle", sorter_clear_a, 0);
        @(posedge clk); #1;
    endtask

    task automatic applyStimulus(input bit with_last, input bit gaps, input bit poke_start);
        bit hs;
        int w;
        for (int i = 0; i < beat_sig.size(); i++) begin
            if (gaps && (i % 2 == 1)) begin
                in_valid_a = 1'b0;
                @(posedge clk); #1;
            end
            in_valid_a     = 1'b1;
            in_signature_a = beat_sig[i];
            in_last_a      = with_last && (i == beat_sig.size() - 1);
            if (poke_start && i == 2) start_a = 1'b1;
            hs = 1'b0;
            w  = 0;
            while (!hs && w < 20) begin
                @(negedge clk);
                hs = in_ready_a;
                @(posedge clk); #1;
                start_a = 1'b0;
                w++;
            end
            if (!hs) checkOutput("in_handshake_timeout", 0, 1);
            hs_last_cycle = cycle;
        end
        in_valid_a = 1'b0;
        in_last_a  = 1'b0;
    endtask

    task automatic collectA(input int stall_at, input bit poke_start);
        bit          fin = 1'b0;
        bit          stalled = 1'b0;
        bit          poked = 1'b0;
        bit          have_held = 1'b0;
        logic [10:0] held = '0;
        int          stall_left = 0;
        int          w = 0;
        got_idx.delete();
        got_last.delete();
        first_valid_cycle = -1;
        stall_errs = 0;
        out_ready_a = 1'b1;
        while (!fin && w < 200) begin
            @(negedge clk);
            if (out_valid_a && first_valid_cycle < 0) first_valid_cycle = cycle;
            if (out_valid_a && !out_ready_a) begin
                if (!have_held) begin
                    held = {out_last_a, out_index_a};
                    have_held = 1'b1;
                end else if ({out_last_a, out_index_a} != held) begin
                    stall_errs++;
                end
            end
            if (out_valid_a && out_ready_a) begin
                got_idx.push_back(int'(out_index_a));
                got_last.push_back(out_last_a);
                fin = out_last_a;
            end
            @(posedge clk); #1;
            w++;
            start_a = 1'b0;
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) out_ready_a = 1'b1;
            end else if (stall_at > 0 && got_idx.size() == stall_at && !stalled) begin
                out_ready_a = 1'b0;
                stall_left  = 5;
                stalled     = 1'b1;
            end
            if (poke_start && got_idx.size() == 1 && !poked) begin
                start_a = 1'b1;
                poked   = 1'b1;
            end
        end
        if (!fin) checkOutput("out_timeout", 0, 1);
        @(negedge clk);
        checkOutput("done_pulse", done_a, 1);
        checkOutput("busy_low_with_done", busy_a, 0);
        @(negedge clk);
        checkOutput("done_one_cycle", done_a, 0);
        out_ready_a = 1'b0;
    endtask

    task automatic checkSketch(input string tag);
        int last_pos = -1;
        int last_cnt = 0;
        checkOutput({tag, "_count"}, got_idx.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_idx.size(); i++)
            checkOutput($sformatf("%s_idx%0d", tag, i), got_idx[i], exp_q[i]);
        for (int i = 0; i < got_last.size(); i++)
            if (got_last[i]) begin last_cnt++; if (last_pos < 0) last_pos = i; end
        checkOutput({tag, "_last_pos"}, last_pos, exp_q.size() - 1);
        checkOutput({tag, "_last_count"}, last_cnt, 1);
    endtask

    task automatic checkLoads(input string tag, input int base, input int n, input bit use_b);
        int bad = 0;
        int size = use_b ? load_q_b.size() : load_q_a.size();
        checkOutput({tag, "_load_count"}, size - base, n);
        for (int i = 0; i < n && base + i < size; i++)
            if ((use_b ? load_q_b[base+i] : load_q_a[base+i]) != i) bad++;
        checkOutput({tag, "_load_seq"}, bad, 0);
    endtask

    initial begin
        int base;
        int clr0;
        int rdy_errs;
        int w;
        bit fin;
        logic [31:0] sig_b [10];

        reset = 1'b1;
        start_a = 0; in_valid_a = 0; in_last_a = 0; in_signature_a = 0; out_ready_a = 0;
        start_b = 0; in_valid_b = 0; in_last_b = 0; in_signature_b = 0; out_ready_b = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_outputs_a", |{busy_a, done_a, overflow_a, in_ready_a, out_valid_a,
                    out_index_a, out_last_a, sorter_clear_a, sorter_load_a,
                    sorter_signature_a, sorter_index_a}, 0);
        checkOutput("reset_outputs_b", |{busy_b, done_b, overflow_b, in_ready_b, out_valid_b,
                    out_index_b, out_last_b, sorter_clear_b, sorter_load_b,
                    sorter_signature_b, sorter_index_b}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        $display("[TB] reset during LOAD");
        startSketchA();
        beat_sig = '{32'd100, 32'd200, 32'd300};
        applyStimulus(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midload_reset_outputs", |{busy_a, done_a, overflow_a, in_ready_a, out_valid_a,
                    out_index_a, out_last_a, sorter_clear_a, sorter_load_a,
                    sorter_signature_a, sorter_index_a}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        $display("[TB] basic 12-beat sketch");
        base = load_q_a.size();
        clr0 = clear_cnt_a;
        startSketchA();
        beat_sig = '{32'd700, 32'd300, 32'd900, 32'd100, 32'd1200, 32'd500,
                     32'd50, 32'd800, 32'd1100, 32'd200, 32'd600, 32'd400};
        applyStimulus(1'b1, 1'b0, 1'b0);
        collectA(0, 1'b0);
        exp_q = '{6, 3, 9, 1, 11, 5, 10, 0};
        checkSketch("basic");
        checkLoads("basic", base, 12, 1'b0);
        checkOutput("basic_valid_latency", first_valid_cycle - hs_last_cycle, 3);
        checkOutput("basic_clear_count", clear_cnt_a - clr0, 1);

        $display("[TB] short 3-beat sketch");
        base = load_q_a.size();
        startSketchA();
        beat_sig = '{32'd50, 32'd10, 32'd30};
        applyStimulus(1'b1, 1'b0, 1'b0);
        collectA(0, 1'b0);
        exp_q = '{1, 2, 0};
        checkSketch("short");
        checkLoads("short", base, 3, 1'b0);

        $display("[TB] backpressure and ignored start");
        base = load_q_a.size();
        clr0 = clear_cnt_a;
        startSketchA();
        beat_sig = '{32'd40, 32'd20, 32'd50, 32'd10, 32'd30};
        applyStimulus(1'b1, 1'b1, 1'b1);
        collectA(2, 1'b1);
        exp_q = '{3, 1, 4, 0, 2};
        checkSketch("bp");
        checkLoads("bp", base, 5, 1'b0);
        checkOutput("bp_stall_stable", stall_errs, 0);
        checkOutput("bp_clear_count", clear_cnt_a - clr0, 1);
        checkOutput("bp_idle_after", busy_a, 0);
        checkOutput("load_trail_errors", trail_errs, 0);

        $display("[TB] index exhaustion with 3-bit indices");
        sig_b = '{32'd80, 32'd70, 32'd60, 32'd50, 32'd40, 32'd30, 32'd20, 32'd10, 32'd5, 32'd1};
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        @(posedge clk); #1;
        rdy_errs = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid_b     = 1'b1;
            in_signature_b = sig_b[i];
            in_last_b      = (i == 9);
            @(negedge clk);
            if (!in_ready_b) rdy_errs++;
            @(posedge clk); #1;
        end
        in_valid_b = 1'b0;
        in_last_b  = 1'b0;
        checkOutput("ovf_in_ready", rdy_errs, 0);
        @(negedge clk);
        checkOutput("ovf_set", overflow_b, 1);
        checkLoads("ovf", 0, 8, 1'b1);
        out_ready_b = 1'b1;
        got_idx.delete();
        got_last.delete();
        fin = 1'b0;
        w = 0;
        while (!fin && w < 50) begin
            @(negedge clk);
            if (out_valid_b) begin
                got_idx.push_back(int'(out_index_b));
                got_last.push_back(out_last_b);
                fin = out_last_b;
            end
            @(posedge clk); #1;
            w++;
        end
        if (!fin) checkOutput("ovf_out_timeout", 0, 1);
        @(negedge clk);
        checkOutput("ovf_done", done_b, 1);
        exp_q = '{7, 6, 5, 4, 3, 2, 1, 0};
        checkSketch("ovf");
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("ovf_sticky_idle", overflow_b, 1);
        checkOutput("ovf_idle_busy", busy_b, 0);
        @(posedge clk); #1;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        @(negedge clk);
        checkOutput("ovf_cleared_on_start", overflow_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
